tt_mux_ctrl: RTL and testbench

Project-select controller for the muxed tile array. It owns the shared 18-bit input bus (iw) that is broadcast to every pNN wrapper, drives the one-hot `ena` lines, and returns the 24-bit output bus (ow) of the active project to the pads. Switching projects follows a fixed sequence: isolate the old project, reset the new one, then run. No two projects are ever enabled in the same cycle.

---
 rtl/tt_mux_pkg.sv | 44 ++++
 rtl/tt_mux_ow_sel.sv | 44 ++++
 rtl/tt_mux_ctrl.sv | 139 +++++++++++++
 tb/tb_tt_mux_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_mux_pkg.sv
// Shared types and bus layout for the tile-array project-select controller.
// Field offsets describe the iw/ow buses seen by every project wrapper.
package tt_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISOLATE,
        ST_RESET,
        ST_RUN
    } state_e;

    localparam int IW_W = 18;
    localparam int OW_W = 24;

    localparam int IW_CLK    = 0;
    localparam int IW_RSTN   = 1;
    localparam int IW_UI_LO  = 2;
    localparam int IW_UI_HI  = 9;
    localparam int IW_UIO_LO = 10;
    localparam int IW_UIO_HI = 17;

    localparam int OW_UO_LO  = 0;
    localparam int OW_UO_HI  = 7;
    localparam int OW_UIO_LO = 8;
    localparam int OW_UIO_HI = 15;
    localparam int OW_OE_LO  = 16;
    localparam int OW_OE_HI  = 23;

    function automatic logic [IW_W-1:0] pack_iw(
        input logic       clk_b,
        input logic       rstn_b,
        input logic [7:0] ui_b,
        input logic [7:0] uio_b
    );
        logic [IW_W-1:0] iw;
        iw                      = '0;
        iw[IW_CLK]              = clk_b;
        iw[IW_RSTN]             = rstn_b;
        iw[IW_UI_HI:IW_UI_LO]   = ui_b;
        iw[IW_UIO_HI:IW_UIO_LO] = uio_b;
        return iw;
    endfunction

endpackage

// File: rtl/tt_mux_ow_sel.sv
// Return-path mux: picks one project's ow word and registers it once.
// clr_i zeroes the register synchronously so the pads never see a stale project.
module tt_mux_ow_sel
    import tt_mux_pkg::*;
#(
    parameter int N_PROJ = 16,
    parameter int SEL_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic [SEL_W-1:0]       sel_i,
    input  logic [N_PROJ*OW_W-1:0] ow_all_i,
    output logic [OW_W-1:0]        ow_o
);

    logic [OW_W-1:0] mux;
    logic [OW_W-1:0] ow_q;
    logic [OW_W-1:0] ow_d;

    always_comb begin
        mux = '0;
        for (int k = 0; k < N_PROJ; k++) begin
            if (sel_i == SEL_W'(k)) begin
                mux = ow_all_i[k*OW_W +: OW_W];
            end
        end
    end

    always_comb begin
        ow_d = clr_i ? '0 : mux;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ow_q <= '0;
        end else begin
            ow_q <= ow_d;
        end
    end

    assign ow_o = ow_q;

endmodule

// File: rtl/tt_mux_ctrl.sv
// Project-select controller: isolate old project, reset new one, then run.
// Owns the shared iw bus, the one-hot ena lines and the registered ow return.
module tt_mux_ctrl
    import tt_mux_pkg::*;
#(
    parameter int N_PROJ     = 16,
    parameter int SEL_W      = 4,
    parameter int RST_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sel_valid,
    output logic                   sel_ready,
    input  logic                   sel_off,
    input  logic [SEL_W-1:0]       sel_addr,
    output logic                   sel_err,
    output logic [SEL_W-1:0]       cur_sel,
    output logic                   active,
    input  logic [7:0]             pad_ui_in,
    input  logic [7:0]             pad_uio_in,
    input  logic                   pad_rst_n,
    output logic [N_PROJ-1:0]      proj_ena,
    output logic [IW_W-1:0]        proj_iw,
    input  logic [N_PROJ*OW_W-1:0] proj_ow_all,
    output logic [OW_W-1:0]        pad_ow
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] tgt_q, tgt_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             off_q, off_d;
    logic             err_q, err_d;
    logic [7:0]       ui_q, uio_q;
    logic             rstn_q;
    logic             accept;
    logic             bad_addr;
    logic             ena_on;
    logic             ow_clr;

    assign sel_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign accept    = sel_valid & sel_ready;
    assign bad_addr  = 32'(sel_addr) >= N_PROJ;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    state_d = ST_ISOLATE;
                    off_d   = sel_off | bad_addr;
                    err_d   = ~sel_off & bad_addr;
                    if (!(sel_off | bad_addr)) begin
                        tgt_d = sel_addr;
                    end
                end
            end
            ST_ISOLATE: begin
                cnt_d   = 8'(RST_CYCLES - 1);
                state_d = off_q ? ST_IDLE : ST_RESET;
            end
            ST_RESET: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
            cnt_q   <= '0;
            off_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ui_q   <= '0;
            uio_q  <= '0;
            rstn_q <= 1'b0;
        end else begin
            ui_q   <= pad_ui_in;
            uio_q  <= pad_uio_in;
            rstn_q <= pad_rst_n;
        end
    end

    assign active  = state_q == ST_RUN;
    assign ena_on  = (state_q == ST_RESET) || active;
    assign cur_sel = active ? tgt_q : '0;
    assign sel_err = err_q;

    always_comb begin
        proj_ena = '0;
        if (ena_on) begin
            proj_ena = N_PROJ'(1) << tgt_q;
        end
    end

    // Pad inputs only reach the project once it is running; RESET holds rst_n low.
    always_comb begin
        proj_iw = pack_iw(clk,
                          active & rstn_q,
                          active ? ui_q : 8'h00,
                          active ? uio_q : 8'h00);
    end

    // Clear on the edge that leaves RUN so ISOLATE already sees pad_ow = 0.
    assign ow_clr = !((state_q == ST_RUN) && (state_d == ST_RUN));

    tt_mux_ow_sel #(
        .N_PROJ (N_PROJ),
        .SEL_W  (SEL_W)
    ) u_ow_sel (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (ow_clr),
        .sel_i    (tgt_q),
        .ow_all_i (proj_ow_all),
        .ow_o     (pad_ow)
    );

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Scoreboard bench for tt_mux_ctrl: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_tt_mux_ctrl;

    localparam int NP = 16;
    localparam int SW = 5;
    localparam int RC = 8;

    localparam int ENA = 0;
    localparam int OW  = 1;
    localparam int IWH = 2;
    localparam int RDY = 3;
    localparam int ERR = 4;
    localparam int CUR = 5;
    localparam int ACT = 6;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] val;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             sel_valid;
    logic             sel_ready;
    logic             sel_off;
    logic [SW-1:0]    sel_addr;
    logic             sel_err;
    logic [SW-1:0]    cur_sel;
    logic             active;
    logic [7:0]       pad_ui_in;
    logic [7:0]       pad_uio_in;
    logic             pad_rst_n;
    logic [NP-1:0]    proj_ena;
    logic [17:0]      proj_iw;
    logic [NP*24-1:0] proj_ow_all;
    logic [23:0]      pad_ow;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    tt_mux_ctrl #(
        .N_PROJ     (NP),
        .SEL_W      (SW),
        .RST_CYCLES (RC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sel_valid   (sel_valid),
        .sel_ready   (sel_ready),
        .sel_off     (sel_off),
        .sel_addr    (sel_addr),
        .sel_err     (sel_err),
        .cur_sel     (cur_sel),
        .active      (active),
        .pad_ui_in   (pad_ui_in),
        .pad_uio_in  (pad_uio_in),
        .pad_rst_n   (pad_rst_n),
        .proj_ena    (proj_ena),
        .proj_iw     (proj_iw),
        .proj_ow_all (proj_ow_all),
        .pad_ow      (pad_ow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Project k presents ow = {k+0x10, k+0x40, k+0x80}.
    initial begin
        for (int k = 0; k < NP; k++) begin
            proj_ow_all[k*24 +: 24] = {8'(k + 16), 8'(k + 64), 8'(k + 128)};
        end
    end

    function automatic string nm(input int id);
        case (id)
            ENA:     return "proj_ena";
            OW:      return "pad_ow";
            IWH:     return "proj_iw_hi";
            RDY:     return "sel_ready";
            ERR:     return "sel_err";
            CUR:     return "cur_sel";
            default: return "active";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int id);
        case (id)
            ENA:     return 32'(proj_ena);
            OW:      return 32'(pad_ow);
            IWH:     return 32'(proj_iw[17:1]);
            RDY:     return 32'(sel_ready);
            ERR:     return 32'(sel_err);
            CUR:     return 32'(cur_sel);
            default: return 32'(active);
        endcase
    endfunction

    task automatic ex(input int c, input int id, input logic [31:0] v);
        exp_t e;
        int   i;
        e.cyc = c;
        e.id  = id;
        e.val = v;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        checks++;
        if ($countones(proj_ena) > 1) begin
            errors++;
            $display("FAIL onehot cyc=%0d proj_ena=%h", cyc, proj_ena);
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s missed cyc=%0d", nm(e.id), e.cyc);
            end else if (actual(e.id) !== e.val) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h exp=%h",
                         nm(e.id), cyc, actual(e.id), e.val);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic request(input logic off, input logic [SW-1:0] addr,
                           output int acc);
        logic rdy;
        acc       = -1;
        sel_valid = 1'b1;
        sel_off   = off;
        sel_addr  = addr;
        for (int b = 0; b < 40; b++) begin
            rdy = sel_ready;
            tick(1);
            if (rdy) begin
                acc = cyc;
                break;
            end
        end
        sel_valid = 1'b0;
        sel_off   = 1'b0;
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout addr=%0d", addr);
        end
    endtask

    initial begin
        int a, b, c, d, e, f, g;
        rst        = 1'b1;
        sel_valid  = 1'b0;
        sel_off    = 1'b0;
        sel_addr   = '0;
        pad_ui_in  = 8'h00;
        pad_uio_in = 8'h00;
        pad_rst_n  = 1'b1;

        ex(1, ENA, 0); ex(1, OW, 0);  ex(1, IWH, 0); ex(1, RDY, 1);
        ex(1, ERR, 0); ex(1, CUR, 0); ex(1, ACT, 0);
        tick(2);
        rst = 1'b0;

        // select 3
        request(1'b0, 5'd3, a);
        ex(a, ENA, 0);         ex(a, OW, 0);          ex(a, RDY, 0);
        ex(a + 1, ENA, 'h8);   ex(a + 1, IWH, 0);
        ex(a + 8, IWH, 0);     ex(a + 8, ACT, 0);     ex(a + 8, ENA, 'h8);
        ex(a + 9, ACT, 1);     ex(a + 9, CUR, 3);     ex(a + 9, OW, 0);
        ex(a + 9, IWH, 'h1);   ex(a + 10, OW, 'h134383);

        // pad inputs reach iw one cycle later
        goto(a + 10);
        pad_ui_in = 8'hA5;
        pad_rst_n = 1'b0;
        ex(a + 10, IWH, 'h1);  ex(a + 11, IWH, 'h14A);
        goto(a + 11);
        pad_ui_in = 8'h00;
        pad_rst_n = 1'b1;
        ex(a + 12, IWH, 'h1);

        // switch 3 -> 5
        goto(a + 12);
        request(1'b0, 5'd5, b);
        ex(b, ENA, 0);         ex(b, OW, 0);          ex(b, ACT, 0);
        ex(b + 1, ENA, 'h20);  ex(b + 1, IWH, 0);
        ex(b + 8, ENA, 'h20);  ex(b + 8, RDY, 0);
        ex(b + 9, RDY, 1);     ex(b + 9, CUR, 5);     ex(b + 9, OW, 0);
        ex(b + 10, OW, 0);

        // request held through RESET lands on the first RUN cycle
        goto(b + 2);
        request(1'b0, 5'd3, c);
        checks++;
        if (c != b + 10) begin
            errors++;
            $display("FAIL held_accept got=%0d exp=%0d", c, b + 10);
        end
        ex(c, ENA, 0);         ex(c, ACT, 0);
        ex(c + 1, ENA, 'h8);   ex(c + 2, RDY, 0);

        // async reset mid-RESET
        goto(c + 3);
        rst = 1'b1;
        ex(c + 3, ENA, 0);     ex(c + 3, IWH, 0);     ex(c + 3, OW, 0);
        ex(c + 3, CUR, 0);     ex(c + 3, ACT, 0);     ex(c + 3, ERR, 0);
        goto(c + 5);
        rst = 1'b0;
        ex(c + 6, RDY, 1);     ex(c + 6, CUR, 0);     ex(c + 6, ENA, 0);

        // out-of-range address
        goto(c + 6);
        request(1'b0, 5'd20, d);
        ex(d, ERR, 1);         ex(d, ENA, 0);         ex(d, RDY, 0);
        ex(d + 1, ERR, 0);     ex(d + 1, RDY, 1);     ex(d + 1, ENA, 0);
        ex(d + 1, ACT, 0);     ex(d + 3, ENA, 0);

        // select 2, then deselect from RUN
        goto(d + 2);
        request(1'b0, 5'd2, e);
        ex(e + 9, CUR, 2);     ex(e + 9, ACT, 1);
        ex(e + 10, OW, 'h124282);                     ex(e + 10, ENA, 'h4);
        ex(e + 11, OW, 'h124282);
        goto(e + 11);
        request(1'b1, 5'd0, f);
        ex(f, ACT, 0);         ex(f, OW, 0);          ex(f, ENA, 0);
        ex(f, ERR, 0);         ex(f + 1, RDY, 1);     ex(f + 1, CUR, 0);
        ex(f + 1, ENA, 0);     ex(f + 1, OW, 0);

        // deselect from IDLE
        goto(f + 2);
        request(1'b1, 5'd0, g);
        ex(g, ERR, 0);         ex(g, RDY, 0);
        ex(g + 1, RDY, 1);     ex(g + 1, ERR, 0);

        for (int i = 0; i < 40 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        tick(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
